// File: rtl/pixel_bank_loader.sv
// Double-buffered display memory: a handshaked byte stream fills the off-screen
// bank while the on-screen bank is read; banks swap only at the start of retrace.
module pixel_bank_loader #(
  parameter int ADDR_WIDTH       = 4,
  parameter int DATA_WIDTH       = 8,
  parameter bit VSYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic                  wr_last,
  input  logic                  vsync,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  disp_bank,
  output logic [7:0]            frames_missed
);

  localparam int                    DEPTH       = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] WPTR_MAX    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic                  VS_INACTIVE = VSYNC_ACTIVE_LOW ? 1'b1 : 1'b0;

  typedef enum logic {FILL, WAIT_SWAP} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   wptr;
  logic                    rdy_q;
  logic                    vsync_d;
  logic                    vs_act;
  logic                    vs_act_d;
  logic                    vs_start;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   mem [2*DEPTH];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Ready is held low combinationally while reset is asserted.
  assign wr_ready = rdy_q & ~reset;
  assign accept   = wr_valid & wr_ready;
  assign vs_act   = VSYNC_ACTIVE_LOW ? ~vsync : vsync;
  assign vs_act_d = VSYNC_ACTIVE_LOW ? ~vsync_d : vsync_d;
  assign vs_start = vs_act & ~vs_act_d;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= FILL;
      wptr          <= '0;
      rdy_q         <= 1'b1;
      vsync_d       <= VS_INACTIVE;
      disp_bank     <= 1'b0;
      frames_missed <= 8'd0;
    end else begin
      vsync_d <= vsync;
      case (state)
        FILL: begin
          if (accept) begin
            if (wr_last || wptr == WPTR_MAX) begin
              state <= WAIT_SWAP;
              rdy_q <= 1'b0;
            end
            // The pointer never wraps by itself; only a swap returns it to zero.
            if (wptr != WPTR_MAX) wptr <= wptr + 1'b1;
          end
          if (vs_start) frames_missed <= sat_inc(frames_missed);
        end
        WAIT_SWAP: begin
          if (vs_start) begin
            disp_bank <= ~disp_bank;
            wptr      <= '0;
            state     <= FILL;
            rdy_q     <= 1'b1;
          end
        end
        default: begin
          state <= FILL;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

  // Writes always target the fill bank, so they never collide with display reads.
  always_ff @(posedge clock) begin
    if (accept) mem[{~disp_bank, wptr}] <= wr_data;
  end

  // Read stage: the swap-cycle read still sees the pre-toggle bank.
  always_ff @(posedge clock) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[{disp_bank, rd_addr}];
  end

endmodule

// File: tb/tb_pixel_bank_loader.sv
// Scoreboarded bench for pixel_bank_loader: reads push expected bytes, a
// negedge monitor pops and compares them against rd_data.
module tb_pixel_bank_loader;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] wr_data;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_last;
  logic       vsync;
  logic [3:0] rd_addr;
  logic [7:0] rd_data;
  logic       disp_bank;
  logic [7:0] frames_missed;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q[$];
  logic       rd_en    = 1'b0;
  logic       rd_en_q  = 1'b0;

  pixel_bank_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .VSYNC_ACTIVE_LOW(1'b1)) dut (
    .clock(clock), .reset(reset), .wr_data(wr_data), .wr_valid(wr_valid),
    .wr_ready(wr_ready), .wr_last(wr_last), .vsync(vsync), .rd_addr(rd_addr),
    .rd_data(rd_data), .disp_bank(disp_bank), .frames_missed(frames_missed)
  );

  always #5 clock = ~clock;

  always @(posedge clock) rd_en_q <= rd_en;

  // Monitor: one read result per issued read, one cycle later.
  always @(negedge clock) begin
    if (rd_en_q) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rd_data: got %02h with no expected entry queued", rd_data);
      end else begin
        automatic logic [7:0] e = exp_q.pop_front();
        if (rd_data !== e) begin
          n_fail++;
          $display("FAIL rd_data: got %02h, expected %02h", rd_data, e);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic check_at_negedge(input string name, input int which, input logic [7:0] exp);
    @(negedge clock);
    case (which)
      0: check(name, {7'd0, wr_ready}, exp);
      1: check(name, {7'd0, disp_bank}, exp);
      2: check(name, frames_missed, exp);
      default: check(name, rd_data, exp);
    endcase
    @(posedge clock); #1;
  endtask

  task automatic write_beat(input logic [7:0] d, input logic last);
    bit done = 0;
    int tries = 0;
    wr_data = d; wr_valid = 1'b1; wr_last = last;
    while (!done && tries < 50) begin
      @(negedge clock);
      if (wr_ready) done = 1;
      @(posedge clock); #1;
      tries++;
    end
    wr_valid = 1'b0; wr_last = 1'b0;
    if (!done) begin
      n_checks++; n_fail++;
      $display("FAIL write_accept: beat %02h not accepted within 50 cycles", d);
    end
  endtask

  task automatic fill(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) write_beat(base + 8'(i), i == n - 1);
  endtask

  task automatic vs_pulse();
    vsync = 1'b0; tick(); tick();
    vsync = 1'b1; tick(); tick();
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    rd_addr = a; rd_en = 1'b1; tick();
    rd_en = 1'b0; tick();
  endtask

  initial begin
    reset = 1'b1; wr_data = 8'h00; wr_valid = 1'b0; wr_last = 1'b0;
    vsync = 1'b1; rd_addr = 4'd0;
    tick(); tick();
    @(negedge clock);
    check("reset_wr_ready", {7'd0, wr_ready}, 8'd0);
    check("reset_rd_data", rd_data, 8'h00);
    check("reset_disp_bank", {7'd0, disp_bank}, 8'd0);
    check("reset_frames_missed", frames_missed, 8'd0);
    @(posedge clock); #1;
    reset = 1'b0;
    check_at_negedge("post_reset_wr_ready", 0, 8'd1);

    // Full fill of bank 1, then swap.
    fill(8'h10, 16);
    check_at_negedge("full_fill_ready_drop", 0, 8'd0);
    check_at_negedge("disp_before_swap1", 1, 8'd0);
    vs_pulse();
    check_at_negedge("disp_after_swap1", 1, 8'd1);
    check_at_negedge("ready_after_swap1", 0, 8'd1);
    check_at_negedge("missed_after_swap1", 2, 8'd0);
    rd(4'd5, 8'h15);
    rd(4'd3, 8'h13);

    // Back-to-back frame into bank 0.
    fill(8'hA0, 16);
    rd(4'd3, 8'h13);
    vs_pulse();
    check_at_negedge("disp_after_swap2", 1, 8'd0);
    rd(4'd3, 8'hA3);
    rd(4'd15, 8'hAF);

    // Early wr_last leaves stale entries in bank 1.
    write_beat(8'h55, 1'b0);
    write_beat(8'h66, 1'b1);
    check_at_negedge("early_last_ready_drop", 0, 8'd0);
    vs_pulse();
    check_at_negedge("disp_after_swap3", 1, 8'd1);
    rd(4'd0, 8'h55);
    rd(4'd1, 8'h66);
    rd(4'd2, 8'h12);

    // Missed frames while idle in FILL.
    for (int i = 0; i < 3; i++) vs_pulse();
    check_at_negedge("missed_3", 2, 8'd3);
    check_at_negedge("missed_3_disp", 1, 8'd1);
    for (int i = 0; i < 297; i++) vs_pulse();
    check_at_negedge("missed_saturate", 2, 8'd255);
    vs_pulse();
    check_at_negedge("missed_hold_255", 2, 8'd255);
    check_at_negedge("missed_disp_unchanged", 1, 8'd1);

    // Swap-cycle read timing: same-cycle read sees old bank, next sees new.
    fill(8'hC0, 16);
    exp_q.push_back(8'h14);
    rd_addr = 4'd4; rd_en = 1'b1; vsync = 1'b0; tick();
    exp_q.push_back(8'hC4);
    tick();
    rd_en = 1'b0; tick();
    check_at_negedge("disp_after_swap4", 1, 8'd0);

    // Inactive-going edge (0->1) must not swap.
    fill(8'hE0, 16);
    vsync = 1'b1; tick(); tick(); tick();
    check_at_negedge("no_swap_on_rise_disp", 1, 8'd0);
    check_at_negedge("no_swap_on_rise_ready", 0, 8'd0);
    check_at_negedge("no_swap_missed", 2, 8'd255);
    vsync = 1'b0; tick(); tick();
    check_at_negedge("disp_after_swap5", 1, 8'd1);
    rd(4'd7, 8'hE7);
    vsync = 1'b1; tick(); tick();

    // Reset mid-fill discards the partial fill.
    for (int i = 0; i < 7; i++) write_beat(8'h30 + 8'(i), 1'b0);
    reset = 1'b1;
    check_at_negedge("midfill_reset_ready", 0, 8'd0);
    reset = 1'b0;
    @(negedge clock);
    check("midfill_reset_disp", {7'd0, disp_bank}, 8'd0);
    check("midfill_reset_missed", frames_missed, 8'd0);
    check("midfill_reset_ready_after", {7'd0, wr_ready}, 8'd1);
    @(posedge clock); #1;
    fill(8'h40, 16);
    vs_pulse();
    check_at_negedge("disp_after_reset_fill", 1, 8'd1);
    rd(4'd0, 8'h40);
    rd(4'd15, 8'h4F);

    tick(); tick(); tick();
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_bank_loader.md
Name: pixel_bank_loader

Overview:
Double-buffered pixel memory that feeds the VGA output stage: its registered read port answers the display's 4-bit address and returns the 8-bit data byte. A byte stream with a valid/ready handshake fills the off-screen bank while the on-screen bank is read. The banks swap only at the start of vertical retrace, so a frame never shows a mix of old and new data. It sits directly upstream of the VGA output stage.

Parameters:
ADDR_WIDTH, 4, entry address width; each bank holds 2^ADDR_WIDTH entries.
DATA_WIDTH, 8, width of one stored entry.
VSYNC_ACTIVE_LOW, 1, 1 means vsync asserts low (640x480 timing); 0 means vsync asserts high.

Ports:
clock  in  1  system clock; the only clock.
reset  in  1  synchronous, active-high reset.
wr_data  in  DATA_WIDTH  incoming entry.
wr_valid  in  1  wr_data is valid.
wr_ready  out  1  block accepts wr_data this cycle.
wr_last  in  1  qualifies wr_data as the final entry of the frame; sampled only on an accepted beat.
vsync  in  1  vertical sync from the timing generator, same clock domain.
rd_addr  in  ADDR_WIDTH  display read address.
rd_data  out  DATA_WIDTH  registered read data from the display bank.
disp_bank  out  1  index of the bank currently on screen.
frames_missed  out  8  saturating count of retrace starts that found no completed fill.

Behaviour:
- Storage: two banks of 2^ADDR_WIDTH x DATA_WIDTH. The display bank is D (= disp_bank); the fill bank is F = ~D. Memory is not cleared by reset, and its contents survive reset.
- Retrace-start event (vs_start): vsync goes from inactive to active level. It is detected with a registered copy vsync_d, which resets to the inactive level, so vs_start is a 1-cycle pulse seen the cycle vsync first samples active.
- FSM states: FILL, WAIT_SWAP.
- FILL:
  - wr_ready = 1.
  - Accept = wr_valid & wr_ready. On accept, write mem[F][wptr] <= wr_data and set wptr <= wptr + 1.
  - If the accept has wr_last = 1, or wptr = 2^ADDR_WIDTH-1, go to WAIT_SWAP next cycle.
  - vs_start while in FILL, including the completing cycle: frames_missed increments, saturating at 255. No swap.
- WAIT_SWAP:
  - wr_ready = 0; wr_valid is ignored.
  - On vs_start: D <= ~D, wptr <= 0, go to FILL. wr_ready = 1 from the following cycle.
- Early wr_last: entries of F above the last written address keep their stale contents and are displayed as such after the swap.
- Read port: rd_data <= mem[D][rd_addr] every cycle, 1-cycle latency.
  - A read issued in the swap cycle uses the pre-toggle D.
  - A read issued one cycle later uses the new D.
  - The write port never targets D, so there are no read/write collisions.
- Reset values: state = FILL, wptr = 0, D = 0, disp_bank = 0, frames_missed = 0, rd_data = 0, vsync_d = inactive. wr_ready = 0 while reset is high and 1 in the first cycle after.
- Reset mid-fill or mid-wait: the partial fill is discarded and the display bank returns to 0. A pending swap is lost.
- Back-pressure: wr_valid may be held high indefinitely. The upstream source holds wr_data/wr_last stable until accepted.
- wptr width is ADDR_WIDTH; wrap to 0 occurs only through the swap path, never by overflow.

Test Plan:
- Reset then full fill: write 0x10..0x1F (16 beats, wr_last on the 16th) -> wr_ready drops the cycle after beat 16. After the first vs_start, disp_bank = 1; rd_addr = 5 gives rd_data = 0x15 one cycle later.
- Back-to-back frames: fill bank 1 with 0x10..0x1F, swap, then fill bank 0 with 0xA0..0xAF. Before the second vs_start, rd_addr = 3 returns 0x13; after it, rd_addr = 3 returns 0xA3 and disp_bank = 0.
- Early wr_last: after the state above, write 0x55, 0x66 with wr_last on beat 2, then vs_start -> addr 0 = 0x55, addr 1 = 0x66, addr 2 = 0x12 (stale bank-1 data).
- Missed frames: hold wr_valid = 0 through 3 vs_start pulses -> frames_missed = 3, disp_bank unchanged. 300 pulses -> frames_missed = 255.
- Swap/read timing and polarity: VSYNC_ACTIVE_LOW = 1, vsync 1->0 while in WAIT_SWAP. A read issued in the swap cycle returns old-bank data; the next cycle's read returns new-bank data. vsync 0->1 produces no swap.
- Reset mid-fill: after 7 accepted beats, pulse reset for 1 cycle -> wr_ready = 0 during reset, disp_bank = 0, frames_missed = 0. A subsequent 16-beat fill plus vs_start gives disp_bank = 1.
